sram_fifo_ctrl: RTL

//  Streaming FIFO controller that drives the 1W1R 16x512 SRAM macro. Port 0 is write, port 1 is read,

---
 rtl/sram_fifo_ctrl.sv | 96 +++++++++
 1 files changed

// File: rtl/sram_fifo_ctrl.sv
// Streaming FIFO controller for a 1W1R SRAM macro (port 0 write, port 1 read).
// A 2-entry registered output buffer hides the one-cycle read latency of the macro.
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int OBUF_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  // Handshakes: a transfer happens on a posedge where valid && ready are both high;
  // valid never depends on ready, and in_ready/out_valid depend only on registered state and rst.

  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, wr_d, rd_d, used;
  logic                  inflight;
  logic [1:0]            obuf_cnt, cnt_d;
  logic [DATA_WIDTH-1:0] obuf0, obuf1, obuf0_d, obuf1_d;
  logic [2:0]            occ_after_pop;
  logic [ADDR_WIDTH+1:0] level_d;
  logic                  push, pop, rd_issue;

  assign used      = wr_ptr - rd_ptr;
  assign in_ready  = !rst && (used != FULL_CNT);
  assign push      = in_valid && in_ready;
  assign out_valid = (obuf_cnt != 2'd0);
  assign out_data  = obuf0;
  assign pop       = out_valid && out_ready;

  // Words already committed to the buffer or in flight, after this cycle's pop.
  assign occ_after_pop = {1'b0, obuf_cnt} + {2'b00, inflight} - {2'b00, pop};
  // wr_ptr only advances at the write edge, so rd_ptr != wr_ptr never selects a word being written now.
  assign rd_issue      = !rst && (rd_ptr != wr_ptr) && (occ_after_pop < 3'(OBUF_DEPTH));

  assign sram_csb0  = !push;
  assign sram_addr0 = wr_ptr[ADDR_WIDTH-1:0];
  assign sram_din0  = in_data;
  assign sram_csb1  = !rd_issue;
  assign sram_addr1 = rd_ptr[ADDR_WIDTH-1:0];

  assign wr_d = wr_ptr + {{ADDR_WIDTH{1'b0}}, push};
  assign rd_d = rd_ptr + {{ADDR_WIDTH{1'b0}}, rd_issue};

  // Pop shifts the buffer first; a capture then lands in the first free slot.
  always_comb begin
    obuf0_d = obuf0;
    obuf1_d = obuf1;
    cnt_d   = obuf_cnt - {1'b0, pop};
    if (pop) obuf0_d = obuf1;
    if (inflight) begin
      if (cnt_d == 2'd0) obuf0_d = sram_dout1;
      else               obuf1_d = sram_dout1;
      cnt_d = cnt_d + 2'd1;
    end
  end

  assign level_d = {1'b0, wr_d - rd_d}
                 + {{(ADDR_WIDTH+1){1'b0}}, rd_issue}
                 + {{ADDR_WIDTH{1'b0}}, cnt_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
      obuf_cnt <= 2'd0;
      obuf0    <= '0;
      obuf1    <= '0;
      level    <= '0;
    end else begin
      wr_ptr   <= wr_d;
      rd_ptr   <= rd_d;
      inflight <= rd_issue;
      obuf_cnt <= cnt_d;
      obuf0    <= obuf0_d;
      obuf1    <= obuf1_d;
      level    <= level_d;
    end
  end

endmodule
